// File: rtl/fsm_se4s_pkg.sv
// Shared types and constants for the se4s phase scheduler and its 4-state sequencer.
package fsm_se4s_pkg;

   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      REST  = 2'b10,
      ABORT = 2'b11
   } ctrl_e;

   // Sequencer phase encoding, shared with the phase-driven datapath.
   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

endpackage

// File: rtl/fsm_se4s_sequencer.sv
// 4-state sequential-encoded sequencer: walks S0->S1->S2->S3->S0, one step per transition strobe.
module fsm_se4s_sequencer
   import fsm_se4s_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       t01_i,
   input  logic       t12_i,
   input  logic       t23_i,
   input  logic       t30_i,
   output logic [1:0] st_o
);

   logic [1:0] st_q, st_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= S0;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         S0: if (t01_i) st_d = S1;
         S1: if (t12_i) st_d = S2;
         S2: if (t23_i) st_d = S3;
         S3: if (t30_i) st_d = S0;
      endcase
   end

   always_comb st_o = st_q;

endmodule

// File: rtl/fsm_se4s_phase_scheduler.sv
// Timed controller generating the sequencer transition strobes with programmable per-phase dwell,
// start/busy/done handshake, abort path and post-run rest interval.
module fsm_se4s_phase_scheduler
   import fsm_se4s_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] dwell0,
   input  logic [CNT_W-1:0] dwell1,
   input  logic [CNT_W-1:0] dwell2,
   input  logic [CNT_W-1:0] dwell3,
   output logic [1:0]       st,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   ctrl_e                  ctrl_q, ctrl_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [3:0][CNT_W-1:0]  sh_q, sh_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   aborted_q, aborted_d;

   logic accept, adv;
   logic t01, t12, t23, t30;

   fsm_se4s_sequencer u_seq (
      .clk   (clk),
      .rst   (rst),
      .t01_i (t01),
      .t12_i (t12),
      .t23_i (t23),
      .t30_i (t30),
      .st_o  (st)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   // Strobes: abort forces the current phase forward regardless of the counter.
   always_comb begin
      accept = (ctrl_q == IDLE) && start && !abort;
      adv    = 1'b0;
      unique case (ctrl_q)
         RUN:     adv = abort || (cnt_q == '0);
         ABORT:   adv = (st != S0);
         default: adv = 1'b0;
      endcase
      t01 = accept;
      t12 = adv && (st == S1);
      t23 = adv && (st == S2);
      t30 = adv && (st == S3);
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      unique case (ctrl_q)
         IDLE: begin
            if (accept) begin
               ctrl_d = RUN;
               cnt_d  = dwell1;
               sh_d   = {dwell3, dwell2, dwell1, dwell0};
            end
         end
         RUN: begin
            if (abort) begin
               ctrl_d = ABORT;
               cnt_d  = '0;
            end else if (cnt_q == '0) begin
               // Next phase's dwell; S3 wraps to the S0 rest dwell.
               cnt_d = sh_q[st + 2'd1];
               if (st == S3) begin
                  ctrl_d = REST;
                  done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         REST: begin
            if (abort) begin
               ctrl_d    = IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (cnt_q == '0) begin
               ctrl_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ABORT: begin
            if (st == S0) begin
               ctrl_d    = IDLE;
               aborted_d = 1'b1;
            end
         end
      endcase
      busy_d = (ctrl_d != IDLE);
   end

   always_comb begin
      busy    = busy_q;
      done    = done_q;
      aborted = aborted_q;
   end

endmodule

// File: tb/tb_fsm_se4s_phase_scheduler.sv
// Self-checking bench: directed vector table, hand sequences and randomized run against a timeline model.
module tb_fsm_se4s_phase_scheduler;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, abort;
   logic [CNT_W-1:0] dwell0, dwell1, dwell2, dwell3;
   logic [1:0]       st;
   logic             busy, done, aborted;

   always #5 clk = ~clk;

   fsm_se4s_phase_scheduler #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .dwell0  (dwell0),
      .dwell1  (dwell1),
      .dwell2  (dwell2),
      .dwell3  (dwell3),
      .st      (st),
      .busy    (busy),
      .done    (done),
      .aborted (aborted)
   );

   typedef struct packed {
      logic [1:0] st;
      logic       busy;
      logic       done;
      logic       aborted;
   } out_t;

   typedef struct {
      logic       start;
      logic       abort;
      logic [7:0] d0, d1, d2, d3;
      out_t       exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Timeline model: the expected outputs of every upcoming cycle are queued when a run or abort begins.
   out_t cur;
   out_t fut[$];
   bit   aborting;

   function automatic out_t mk(input int s, input bit b, input bit d, input bit a);
      out_t o;
      o.st      = 2'(s);
      o.busy    = b;
      o.done    = d;
      o.aborted = a;
      return o;
   endfunction

   function automatic out_t dut_out();
      return {st, busy, done, aborted};
   endfunction

   function automatic vec_t mkv(input bit s, input bit a, input int d0, input int d1,
                                input int d2, input int d3, input out_t e);
      vec_t v;
      v.start = s;  v.abort = a;
      v.d0 = 8'(d0); v.d1 = 8'(d1); v.d2 = 8'(d2); v.d3 = 8'(d3);
      v.exp = e;
      return v;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d busy=%0b done=%0b aborted=%0b, want st=%0d busy=%0b done=%0b aborted=%0b",
                  name, act.st, act.busy, act.done, act.aborted, exp.st, exp.busy, exp.done, exp.aborted);
      end
   endtask

   task automatic model_reset();
      fut.delete();
      cur      = mk(0, 0, 0, 0);
      aborting = 1'b0;
   endtask

   task automatic model_edge();
      if (cur.busy && !aborting && abort) begin
         fut.delete();
         if (cur.st != 2'd0) begin
            for (int p = int'(cur.st) + 1; p <= 3; p++) fut.push_back(mk(p, 1, 0, 0));
            fut.push_back(mk(0, 1, 0, 0));
         end
         fut.push_back(mk(0, 0, 0, 1));
         aborting = 1'b1;
      end else if (!cur.busy && start && !abort) begin
         aborting = 1'b0;
         fut.delete();
         repeat (int'(dwell1) + 1) fut.push_back(mk(1, 1, 0, 0));
         repeat (int'(dwell2) + 1) fut.push_back(mk(2, 1, 0, 0));
         repeat (int'(dwell3) + 1) fut.push_back(mk(3, 1, 0, 0));
         fut.push_back(mk(0, 1, 1, 0));
         repeat (int'(dwell0)) fut.push_back(mk(0, 1, 0, 0));
      end
      if (fut.size() > 0) cur = fut.pop_front();
      else                cur = mk(0, 0, 0, 0);
   endtask

   task automatic tick(input string name);
      @(posedge clk);
      model_edge();
      #1;
      check(name, dut_out(), cur);
   endtask

   task automatic set_dwells(input int d0, input int d1, input int d2, input int d3);
      dwell0 = 8'(d0); dwell1 = 8'(d1); dwell2 = 8'(d2); dwell3 = 8'(d3);
   endtask

   vec_t tbl[26];

   initial begin
      // Nominal run (d0=3,d1=2,d2=0,d3=1), then abort+start in IDLE.
      tbl[0]  = mkv(1, 0, 3, 2, 0, 1, mk(1, 1, 0, 0));
      tbl[1]  = mkv(0, 0, 3, 2, 0, 1, mk(1, 1, 0, 0));
      tbl[2]  = mkv(0, 0, 3, 2, 0, 1, mk(1, 1, 0, 0));
      tbl[3]  = mkv(0, 0, 3, 2, 0, 1, mk(2, 1, 0, 0));
      tbl[4]  = mkv(0, 0, 3, 2, 0, 1, mk(3, 1, 0, 0));
      tbl[5]  = mkv(0, 0, 3, 2, 0, 1, mk(3, 1, 0, 0));
      tbl[6]  = mkv(0, 0, 3, 2, 0, 1, mk(0, 1, 1, 0));
      tbl[7]  = mkv(0, 0, 3, 2, 0, 1, mk(0, 1, 0, 0));
      tbl[8]  = mkv(0, 0, 3, 2, 0, 1, mk(0, 1, 0, 0));
      tbl[9]  = mkv(0, 0, 3, 2, 0, 1, mk(0, 1, 0, 0));
      tbl[10] = mkv(0, 0, 3, 2, 0, 1, mk(0, 0, 0, 0));
      tbl[11] = mkv(1, 1, 3, 2, 0, 1, mk(0, 0, 0, 0));
      tbl[12] = mkv(0, 1, 3, 2, 0, 1, mk(0, 0, 0, 0));
      // Abort in the second S1 cycle with dwell1=5.
      tbl[13] = mkv(1, 0, 0, 5, 0, 0, mk(1, 1, 0, 0));
      tbl[14] = mkv(0, 0, 0, 5, 0, 0, mk(1, 1, 0, 0));
      tbl[15] = mkv(0, 1, 0, 5, 0, 0, mk(2, 1, 0, 0));
      tbl[16] = mkv(0, 0, 0, 5, 0, 0, mk(3, 1, 0, 0));
      tbl[17] = mkv(0, 0, 0, 5, 0, 0, mk(0, 1, 0, 0));
      tbl[18] = mkv(0, 0, 0, 5, 0, 0, mk(0, 0, 0, 1));
      tbl[19] = mkv(0, 0, 0, 5, 0, 0, mk(0, 0, 0, 0));
      // Abort in the t30 cycle: no REST, no done.
      tbl[20] = mkv(1, 0, 2, 0, 0, 0, mk(1, 1, 0, 0));
      tbl[21] = mkv(0, 0, 2, 0, 0, 0, mk(2, 1, 0, 0));
      tbl[22] = mkv(0, 0, 2, 0, 0, 0, mk(3, 1, 0, 0));
      tbl[23] = mkv(0, 1, 2, 0, 0, 0, mk(0, 1, 0, 0));
      tbl[24] = mkv(0, 0, 2, 0, 0, 0, mk(0, 0, 0, 1));
      tbl[25] = mkv(0, 0, 2, 0, 0, 0, mk(0, 0, 0, 0));

      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      set_dwells(0, 0, 0, 0);
      model_reset();
      #7;
      check("reset_state", dut_out(), mk(0, 0, 0, 0));
      #1 rst = 1'b0;

      for (int i = 0; i < 26; i++) begin
         start = tbl[i].start;
         abort = tbl[i].abort;
         set_dwells(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
         tick("model_tbl");
         check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
      end
      start = 1'b0;
      abort = 1'b0;

      // Start held high: the second run only begins after busy drops, with the dwells present then.
      start = 1'b1;
      set_dwells(1, 1, 1, 1);
      tick("held_accept");
      check("held_first_s1", dut_out(), mk(1, 1, 0, 0));
      set_dwells(0, 2, 1, 0);
      for (int i = 0; i < 20; i++) tick("held_start");
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick("held_drain");

      // Long dwells, asynchronous reset in the middle of S2.
      set_dwells(255, 255, 255, 255);
      start = 1'b1;
      tick("ff_accept");
      start = 1'b0;
      for (int i = 0; i < 300; i++) tick("ff_run");
      check("ff_mid_s2", dut_out(), mk(2, 1, 0, 0));
      #3 rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_same_cycle", dut_out(), mk(0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("async_rst_held", dut_out(), mk(0, 0, 0, 0));
      rst = 1'b0;
      tick("post_rst_idle");
      set_dwells(0, 1, 2, 0);
      start = 1'b1;
      tick("post_rst_accept");
      check("post_rst_s1", dut_out(), mk(1, 1, 0, 0));
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick("post_rst_run");

      // Randomized traffic against the timeline model.
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 9) == 0)
            set_dwells($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         else
            set_dwells($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
         tick("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
